// File: rtl/vga_mem_wr_ctrl_if.sv
// Pixel stream and BRAM port B bundle for the frame-buffer write controller.
interface vga_mem_wr_ctrl_if #(
  parameter int unsigned PXL_WIDTH      = 1,
  parameter int unsigned MEM_WIDTH      = 8,
  parameter int unsigned MEM_ADDR_WIDTH = 16
);
  logic [PXL_WIDTH-1:0]      pxl;
  logic                      pxl_valid;
  logic                      pxl_ready;
  logic                      sof;
  logic                      flush;
  logic                      mem_gnt;
  logic                      mem_en;
  logic                      mem_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_WIDTH-1:0]      mem_data;

  // Controller side: consumes pixels, drives the BRAM write port.
  modport slave (
    input  pxl, pxl_valid, sof, flush, mem_gnt,
    output pxl_ready, mem_en, mem_we, mem_addr, mem_data
  );

  // Producer/arbiter side.
  modport master (
    output pxl, pxl_valid, sof, flush, mem_gnt,
    input  pxl_ready, mem_en, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/vga_mem_wr_ctrl.sv
// Frame-buffer write controller: packs pixels into BRAM words and writes them
// to port B at a linear address that wraps once per frame.
module vga_mem_wr_ctrl #(
  parameter int unsigned PXL_WIDTH      = 1,
  parameter int unsigned PXL_PER_ROW    = 8,
  parameter int unsigned MEM_WIDTH      = PXL_PER_ROW * PXL_WIDTH,
  parameter int unsigned MEM_DEPTH      = 38400,
  parameter int unsigned MEM_ADDR_WIDTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  vga_mem_wr_ctrl_if.slave  bus,
  output logic              frame_done_o,
  output logic              sof_err_o
);

  localparam int unsigned CTR_W = (PXL_PER_ROW > 1) ? $clog2(PXL_PER_ROW) : 1;
  localparam logic [CTR_W-1:0]          LAST_SLOT = CTR_W'(PXL_PER_ROW - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = MEM_ADDR_WIDTH'(MEM_DEPTH - 1);

  logic [CTR_W-1:0]          pack_ctr_q, pack_ctr_d;
  logic [MEM_WIDTH-1:0]      pack_reg_q, pack_reg_d;
  logic [MEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                      hold_valid_q, hold_valid_d;
  logic [MEM_ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [MEM_WIDTH-1:0]      hold_data_q, hold_data_d;
  logic                      flush_pend_q, flush_pend_d;
  logic                      frame_done_q, frame_done_d;
  logic                      sof_err_q, sof_err_d;
  logic                      rst_q;

  logic                      ready;
  logic                      accept;
  logic                      commit;
  logic                      hold_free;
  logic                      flush_go;
  logic [CTR_W-1:0]          cur_ctr;
  logic [MEM_WIDTH-1:0]      cur_reg;
  logic [MEM_WIDTH-1:0]      new_reg;
  logic [MEM_ADDR_WIDTH-1:0] cur_addr;

  // Explicit wrap; the address width may exceed what the frame needs.
  function automatic logic [MEM_ADDR_WIDTH-1:0] next_addr(input logic [MEM_ADDR_WIDTH-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // Handshake and commit qualifiers, all from registered state.
  always_comb begin
    ready     = ~rst_q & ~flush_pend_q & ~(hold_valid_q & (pack_ctr_q == LAST_SLOT));
    accept    = bus.pxl_valid & ready;
    commit    = hold_valid_q & bus.mem_gnt;
    hold_free = ~hold_valid_q | commit;
    flush_go  = flush_pend_q & hold_free;
  end

  // Next-state: pixel packing, sof realignment, flush of a partial word.
  always_comb begin
    pack_ctr_d   = pack_ctr_q;
    pack_reg_d   = pack_reg_q;
    wr_addr_d    = wr_addr_q;
    hold_valid_d = hold_valid_q & ~commit;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    flush_pend_d = flush_pend_q;
    sof_err_d    = sof_err_q;
    frame_done_d = commit & (hold_addr_q == LAST_ADDR);
    cur_ctr      = pack_ctr_q;
    cur_reg      = pack_reg_q;
    cur_addr     = wr_addr_q;
    new_reg      = '0;

    if (accept) begin
      // sof restarts packing at slot 0 of address 0; a pending hold word is untouched.
      if (bus.sof) begin
        if ((pack_ctr_q != '0) || (wr_addr_q != '0)) begin
          sof_err_d = 1'b1;
        end
        cur_ctr  = '0;
        cur_reg  = '0;
        cur_addr = '0;
      end
      new_reg = cur_reg;
      for (int i = 0; i < int'(PXL_PER_ROW); i++) begin
        if (cur_ctr == CTR_W'(i)) begin
          new_reg[i*PXL_WIDTH +: PXL_WIDTH] = bus.pxl;
        end
      end
      // Ready guarantees the hold slot is empty when the last slot fills.
      if (cur_ctr == LAST_SLOT) begin
        hold_data_d  = new_reg;
        hold_addr_d  = cur_addr;
        hold_valid_d = 1'b1;
        pack_ctr_d   = '0;
        pack_reg_d   = '0;
        wr_addr_d    = next_addr(cur_addr);
      end else begin
        pack_reg_d = new_reg;
        pack_ctr_d = cur_ctr + 1'b1;
        wr_addr_d  = cur_addr;
      end
    end else if (flush_go && (pack_ctr_q != '0)) begin
      hold_data_d  = pack_reg_q;
      hold_addr_d  = wr_addr_q;
      hold_valid_d = 1'b1;
      pack_ctr_d   = '0;
      pack_reg_d   = '0;
      wr_addr_d    = next_addr(wr_addr_q);
    end

    // A second flush request while one is pending is absorbed.
    if (flush_pend_q) begin
      flush_pend_d = ~flush_go;
    end else begin
      flush_pend_d = bus.flush;
    end
  end

  // State registers with synchronous reset; a pending hold word is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rst_q        <= 1'b1;
      pack_ctr_q   <= '0;
      pack_reg_q   <= '0;
      wr_addr_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      flush_pend_q <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      rst_q        <= 1'b0;
      pack_ctr_q   <= pack_ctr_d;
      pack_reg_q   <= pack_reg_d;
      wr_addr_q    <= wr_addr_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      flush_pend_q <= flush_pend_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
    end
  end

  assign bus.pxl_ready = ready;
  assign bus.mem_en    = hold_valid_q;
  assign bus.mem_we    = hold_valid_q;
  assign bus.mem_addr  = hold_addr_q;
  assign bus.mem_data  = hold_data_q;
  assign frame_done_o  = frame_done_q;
  assign sof_err_o     = sof_err_q;

endmodule

// File: tb/tb_vga_mem_wr_ctrl.sv
// Directed bench for vga_mem_wr_ctrl with a reduced frame depth.
module tb_vga_mem_wr_ctrl;
  localparam int unsigned PW    = 1;
  localparam int unsigned PPR   = 8;
  localparam int unsigned MW    = 8;
  localparam int unsigned DEPTH = 12;
  localparam int unsigned AW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_done;
  logic sof_err;

  always #5 clk = ~clk;

  vga_mem_wr_ctrl_if #(.PXL_WIDTH(PW), .MEM_WIDTH(MW), .MEM_ADDR_WIDTH(AW)) bus ();

  vga_mem_wr_ctrl #(
    .PXL_WIDTH      (PW),
    .PXL_PER_ROW    (PPR),
    .MEM_WIDTH      (MW),
    .MEM_DEPTH      (DEPTH),
    .MEM_ADDR_WIDTH (AW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .frame_done_o (frame_done),
    .sof_err_o    (sof_err)
  );

  int checks = 0;
  int passes = 0;

  // Write-port monitor.
  logic [AW-1:0] wa_log [256];
  logic [MW-1:0] wd_log [256];
  int n_wr = 0;
  int we_cycles = 0;
  int cyc = 0;
  int fd_count = 0;
  int fd_cyc = -1;
  int last_commit_cyc = -10;
  int stab_err = 0;
  logic prev_hold = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [MW-1:0] prev_data = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_we) we_cycles <= we_cycles + 1;
    if (bus.mem_en && bus.mem_we && bus.mem_gnt && n_wr < 256) begin
      wa_log[n_wr] <= bus.mem_addr;
      wd_log[n_wr] <= bus.mem_data;
      n_wr <= n_wr + 1;
      if (bus.mem_addr == AW'(DEPTH - 1)) last_commit_cyc <= cyc;
    end
    if (frame_done) begin
      fd_count <= fd_count + 1;
      fd_cyc <= cyc;
    end
    if (prev_hold && bus.mem_en && (bus.mem_addr !== prev_addr || bus.mem_data !== prev_data))
      stab_err <= stab_err + 1;
    prev_hold <= bus.mem_en & ~bus.mem_gnt;
    prev_addr <= bus.mem_addr;
    prev_data <= bus.mem_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one pixel and wait (bounded) for it to be accepted; leaves valid high.
  task automatic push(input logic p, input logic s, output int stalls);
    stalls = 0;
    bus.pxl = p;
    bus.sof = s;
    bus.pxl_valid = 1'b1;
    while (!bus.pxl_ready && stalls < 50) begin
      step();
      stalls++;
    end
    if (stalls >= 50) chk("push_ready", 32'(bus.pxl_ready), 32'd1);
    step();
    bus.sof = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] w, input logic first_sof);
    int st;
    for (int j = 0; j < 8; j++) push(w[j], (j == 0) ? first_sof : 1'b0, st);
  endtask

  task automatic idle();
    bus.pxl_valid = 1'b0;
    bus.sof = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base, webase, fdb, stalls, st, idx;
    logic rdy;
    logic [7:0] w0, w1, pat;

    bus.pxl = '0;
    bus.pxl_valid = 1'b0;
    bus.sof = 1'b0;
    bus.flush = 1'b0;
    bus.mem_gnt = 1'b0;

    // Reset state.
    rst = 1'b1;
    repeat (3) step();
    chk("rst_ready", 32'(bus.pxl_ready), 32'd0);
    chk("rst_en", 32'(bus.mem_en), 32'd0);
    chk("rst_sof_err", 32'(sof_err), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(bus.pxl_ready), 32'd1);

    // Alternating 1,0 stream: two words of 8'h55 at back-to-back addresses.
    bus.mem_gnt = 1'b1;
    base = n_wr;
    webase = we_cycles;
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      push((i % 2) == 0, 1'b0, st);
      stalls += st;
    end
    idle();
    repeat (4) step();
    chk("t1_nwr", 32'(n_wr - base), 32'd2);
    chk("t1_addr0", 32'(wa_log[base]), 32'd0);
    chk("t1_data0", 32'(wd_log[base]), 32'h55);
    chk("t1_addr1", 32'(wa_log[base+1]), 32'd1);
    chk("t1_data1", 32'(wd_log[base+1]), 32'h55);
    chk("t1_we_cycles", 32'(we_cycles - webase), 32'd2);
    chk("t1_ready_stalls", 32'(stalls), 32'd0);

    // Full frame plus one word: wrap and frame_done timing.
    do_reset();
    base = n_wr;
    fdb = fd_count;
    for (int w = 0; w < int'(DEPTH) + 1; w++) begin
      pat = 8'(w * 37 + 5);
      push_word(pat, 1'b0);
    end
    idle();
    repeat (4) step();
    chk("t2_nwr", 32'(n_wr - base), 32'(DEPTH + 1));
    chk("t2_last_addr", 32'(wa_log[base+11]), 32'd11);
    chk("t2_last_data", 32'(wd_log[base+11]), 32'h9C);
    chk("t2_wrap_addr", 32'(wa_log[base+12]), 32'd0);
    chk("t2_wrap_data", 32'(wd_log[base+12]), 32'hC1);
    chk("t2_fd_count", 32'(fd_count - fdb), 32'd1);
    chk("t2_fd_timing", 32'(fd_cyc - last_commit_cyc), 32'd1);

    // Backpressure: grant withheld for 20 cycles while 16 pixels are offered.
    do_reset();
    bus.mem_gnt = 1'b0;
    base = n_wr;
    w0 = 8'hA3;
    w1 = 8'h3C;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      bus.pxl = (idx < 8) ? w0[idx] : w1[idx-8];
      bus.pxl_valid = 1'b1;
      rdy = bus.pxl_ready;
      step();
      if (rdy) idx++;
    end
    chk("t3_accepted", 32'(idx), 32'd15);
    chk("t3_ready_low", 32'(bus.pxl_ready), 32'd0);
    chk("t3_hold_en", 32'(bus.mem_en), 32'd1);
    chk("t3_hold_addr", 32'(bus.mem_addr), 32'd0);
    chk("t3_hold_data", 32'(bus.mem_data), 32'hA3);
    chk("t3_no_commit", 32'(n_wr - base), 32'd0);
    bus.mem_gnt = 1'b1;
    for (int c = 0; c < 10 && idx < 16; c++) begin
      bus.pxl = w1[idx-8];
      rdy = bus.pxl_ready;
      step();
      if (rdy) idx++;
    end
    idle();
    chk("t3_all_accepted", 32'(idx), 32'd16);
    repeat (4) step();
    chk("t3_nwr", 32'(n_wr - base), 32'd2);
    chk("t3_addr0", 32'(wa_log[base]), 32'd0);
    chk("t3_data0", 32'(wd_log[base]), 32'hA3);
    chk("t3_addr1", 32'(wa_log[base+1]), 32'd1);
    chk("t3_data1", 32'(wd_log[base+1]), 32'h3C);
    chk("t3_stable", 32'(stab_err), 32'd0);

    // Flush of a 3-pixel partial word, then an empty flush.
    do_reset();
    base = n_wr;
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, st);
    idle();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("t4_ready_pending", 32'(bus.pxl_ready), 32'd0);
    repeat (4) step();
    chk("t4_nwr", 32'(n_wr - base), 32'd1);
    chk("t4_addr", 32'(wa_log[base]), 32'd0);
    chk("t4_data", 32'(wd_log[base]), 32'h07);
    push_word(8'hFF, 1'b0);
    idle();
    repeat (4) step();
    chk("t4_next_addr", 32'(wa_log[base+1]), 32'd1);
    chk("t4_next_data", 32'(wd_log[base+1]), 32'hFF);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    repeat (5) step();
    chk("t4_empty_flush", 32'(n_wr - base), 32'd2);

    // Misaligned sof after 5 pixels.
    do_reset();
    base = n_wr;
    for (int i = 0; i < 5; i++) push(1'b1, 1'b0, st);
    push_word(8'h81, 1'b1);
    idle();
    repeat (4) step();
    chk("t5_sof_err", 32'(sof_err), 32'd1);
    chk("t5_nwr", 32'(n_wr - base), 32'd1);
    chk("t5_addr", 32'(wa_log[base]), 32'd0);
    chk("t5_data", 32'(wd_log[base]), 32'h81);

    // Reset while a word waits for grant.
    do_reset();
    chk("t6_sof_err_clr", 32'(sof_err), 32'd0);
    bus.mem_gnt = 1'b0;
    base = n_wr;
    push_word(8'hFF, 1'b0);
    idle();
    step();
    chk("t6_hold_before", 32'(bus.mem_en), 32'd1);
    rst = 1'b1;
    step();
    chk("t6_rst_en", 32'(bus.mem_en), 32'd0);
    chk("t6_rst_we", 32'(bus.mem_we), 32'd0);
    chk("t6_rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("t6_rst_data", 32'(bus.mem_data), 32'd0);
    chk("t6_rst_ready", 32'(bus.pxl_ready), 32'd0);
    chk("t6_rst_fd", 32'(frame_done), 32'd0);
    bus.mem_gnt = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("t6_no_write", 32'(n_wr - base), 32'd0);
    chk("t6_ready", 32'(bus.pxl_ready), 32'd1);
    push_word(8'h0F, 1'b1);
    idle();
    repeat (4) step();
    chk("t6_nwr", 32'(n_wr - base), 32'd1);
    chk("t6_addr", 32'(wa_log[base]), 32'd0);
    chk("t6_data", 32'(wd_log[base]), 32'h0F);
    chk("t6_aligned_sof", 32'(sof_err), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
